// File: rtl/stage_mem.sv
// Memory-access pipeline stage: latches execute outputs, runs the data-memory
// req/ready handshake and produces the write-back word. Optional: MEM_ALIGN_CHECK_EN.
module stage_mem #(
  parameter int RFSRC_W = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [31:0]        ex_inst,
  input  logic [31:0]        ex_opResult,
  input  logic               ex_memWE,
  input  logic [31:0]        ex_memData,
  input  logic               ex_rfWE,
  input  logic [4:0]         ex_rfDst,
  input  logic [RFSRC_W-1:0] ex_rfSrc,
  output logic               stall,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [31:0]        dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_ready,
  input  logic [31:0]        dmem_rdata,
  output logic [31:0]        mem_inst,
  output logic               mem_rfWE,
  output logic [4:0]         mem_rfDst,
  output logic [31:0]        mem_rfData,
  output logic               mem_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [31:0]        m_inst, m_opResult, m_memData;
  logic               m_memWE, m_rfWE;
  logic [4:0]         m_rfDst;
  logic [RFSRC_W-1:0] m_rfSrc;
  logic [0:0]         state;
  logic [7:0]         cnt;
  logic               memop, misalign, in_wait, issue, done, tmo;

  always_comb begin
    memop    = m_memWE | (m_rfSrc == RFSRC_W'(1));
`ifdef MEM_ALIGN_CHECK_EN
    misalign = memop & (|m_opResult[1:0]);
`else
    misalign = 1'b0;
`endif
    in_wait  = (state == S_WAIT);
    issue    = ~in_wait & memop & ~misalign;
    done     = in_wait & dmem_ready;
    // Abandon on the last permitted wait cycle so the next instruction enters at that edge
    tmo      = in_wait & ~dmem_ready & (cnt == 8'(TIMEOUT - 1));
    stall    = issue | (in_wait & ~dmem_ready & ~tmo);
    dmem_req = issue | in_wait;
  end

  assign dmem_we    = m_memWE;
  assign dmem_addr  = {m_opResult[31:2], 2'b00};
  assign dmem_wdata = m_memData;

  // M latch: flush only applies when the upstream is actually advancing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_inst <= '0; m_opResult <= '0; m_memData <= '0;
      m_memWE <= 1'b0; m_rfWE <= 1'b0; m_rfDst <= '0; m_rfSrc <= '0;
    end else if (!stall) begin
      if (flush) begin
        m_inst <= '0; m_opResult <= '0; m_memData <= '0;
        m_memWE <= 1'b0; m_rfWE <= 1'b0; m_rfDst <= '0; m_rfSrc <= '0;
      end else begin
        m_inst <= ex_inst; m_opResult <= ex_opResult; m_memData <= ex_memData;
        m_memWE <= ex_memWE; m_rfWE <= ex_rfWE; m_rfDst <= ex_rfDst; m_rfSrc <= ex_rfSrc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (in_wait) begin
      if (done || tmo) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end else if (issue) begin
      state <= S_WAIT;
    end
  end

  // Write-back: completion, bubble on any stalled/abandoned cycle, else the ALU path
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_inst <= '0; mem_rfWE <= 1'b0; mem_rfDst <= '0; mem_rfData <= '0; mem_err <= 1'b0;
    end else begin
      mem_err <= tmo | (misalign & ~in_wait);
      if (done) begin
        mem_inst   <= m_inst;
        mem_rfWE   <= m_rfWE & ~m_memWE;
        mem_rfDst  <= m_rfDst;
        mem_rfData <= m_memWE ? m_opResult : dmem_rdata;
      end else if (stall || tmo || misalign) begin
        mem_inst <= '0; mem_rfWE <= 1'b0; mem_rfDst <= '0; mem_rfData <= '0;
      end else begin
        mem_inst   <= m_inst;
        mem_rfWE   <= m_rfWE & ~m_memWE;
        mem_rfDst  <= m_rfDst;
        mem_rfData <= m_opResult;
      end
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Directed self-checking bench for stage_mem (TIMEOUT overridden to 4).
module tb_stage_mem;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic [31:0] ex_inst, ex_opResult, ex_memData;
  logic        ex_memWE, ex_rfWE;
  logic [4:0]  ex_rfDst;
  logic [1:0]  ex_rfSrc;
  logic        stall, dmem_req, dmem_we, dmem_ready, mem_rfWE, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, mem_inst, mem_rfData;
  logic [4:0]  mem_rfDst;
  int          n_pass = 0, n_total = 0;

  stage_mem #(.RFSRC_W(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_inst(ex_inst), .ex_opResult(ex_opResult), .ex_memWE(ex_memWE),
    .ex_memData(ex_memData), .ex_rfWE(ex_rfWE), .ex_rfDst(ex_rfDst), .ex_rfSrc(ex_rfSrc),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_inst(mem_inst), .mem_rfWE(mem_rfWE), .mem_rfDst(mem_rfDst),
    .mem_rfData(mem_rfData), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic set_ex(input logic [31:0] inst, input logic [31:0] res, input logic we,
                        input logic [31:0] wd, input logic rfwe, input logic [4:0] dst,
                        input logic [1:0] src);
    ex_inst = inst; ex_opResult = res; ex_memWE = we; ex_memData = wd;
    ex_rfWE = rfwe; ex_rfDst = dst; ex_rfSrc = src;
  endtask

  task automatic nop();
    set_ex(32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 2'd0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
    nop();
    #3;
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_rfwe", {31'h0, mem_rfWE}, 32'h0);
    chk("rst_err", {31'h0, mem_err}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // ALU op: latency 1, never stalls
    @(negedge clk); set_ex(32'h11, 32'h1234, 1'b0, 32'h0, 1'b1, 5'd5, 2'd0);
    @(negedge clk); chk("alu_stall", {31'h0, stall}, 32'h0); nop();
    @(negedge clk);
    chk("alu_data", mem_rfData, 32'h1234);
    chk("alu_rfwe", {31'h0, mem_rfWE}, 32'h1);
    chk("alu_dst", {27'h0, mem_rfDst}, 32'd5);
    chk("alu_inst", mem_inst, 32'h11);
    chk("alu_stall2", {31'h0, stall}, 32'h0);

    // Load at 0x40: three stalled cycles, ready arrives in the fourth
    set_ex(32'h22, 32'h40, 1'b0, 32'h0, 1'b1, 5'd7, 2'd1);
    @(negedge clk);
    chk("ld_req", {31'h0, dmem_req}, 32'h1);
    chk("ld_we", {31'h0, dmem_we}, 32'h0);
    chk("ld_addr", dmem_addr, 32'h40);
    chk("ld_stall1", {31'h0, stall}, 32'h1);
    nop();
    @(negedge clk);
    chk("ld_stall2", {31'h0, stall}, 32'h1);
    chk("ld_bubble1", {31'h0, mem_rfWE}, 32'h0);
    @(negedge clk);
    chk("ld_stall3", {31'h0, stall}, 32'h1);
    chk("ld_bubble2", {31'h0, mem_rfWE}, 32'h0);
    @(negedge clk);
    dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1 chk("ld_done_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    chk("ld_data", mem_rfData, 32'hDEADBEEF);
    chk("ld_rfwe", {31'h0, mem_rfWE}, 32'h1);
    chk("ld_dst", {27'h0, mem_rfDst}, 32'd7);
    chk("ld_req_off", {31'h0, dmem_req}, 32'h0);
    @(negedge clk);
    chk("ld_once", {31'h0, mem_rfWE}, 32'h0);

    // Store at 0x80, ready on first WAIT cycle; never writes the register file
    set_ex(32'h33, 32'h80, 1'b1, 32'hA5A5A5A5, 1'b1, 5'd3, 2'd0);
    @(negedge clk);
    chk("st_req", {31'h0, dmem_req}, 32'h1);
    chk("st_we", {31'h0, dmem_we}, 32'h1);
    chk("st_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("st_addr", dmem_addr, 32'h80);
    nop();
    @(negedge clk);
    dmem_ready = 1'b1;
    #1 chk("st_done_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    dmem_ready = 1'b0;
    chk("st_rfwe", {31'h0, mem_rfWE}, 32'h0);
    chk("st_data", mem_rfData, 32'h80);

    // Timeout after 4 WAIT cycles; held ALU op enters at the abandon edge
    set_ex(32'h44, 32'h100, 1'b0, 32'h0, 1'b1, 5'd9, 2'd1);
    @(negedge clk);
    chk("to_req", {31'h0, dmem_req}, 32'h1);
    set_ex(32'h55, 32'h55, 1'b0, 32'h0, 1'b1, 5'd2, 2'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("to_stall_w%0d", i), {31'h0, stall}, 32'h1);
      chk($sformatf("to_err_w%0d", i), {31'h0, mem_err}, 32'h0);
    end
    @(negedge clk);
    chk("to_stall_w4", {31'h0, stall}, 32'h0);
    chk("to_err_w4", {31'h0, mem_err}, 32'h0);
    @(negedge clk);
    chk("to_err", {31'h0, mem_err}, 32'h1);
    chk("to_bubble", {31'h0, mem_rfWE}, 32'h0);
    chk("to_req_off", {31'h0, dmem_req}, 32'h0);
    nop();
    @(negedge clk);
    chk("to_err_pulse", {31'h0, mem_err}, 32'h0);
    chk("to_next_data", mem_rfData, 32'h55);
    chk("to_next_dst", {27'h0, mem_rfDst}, 32'd2);

    // Flush a load while not stalled
    set_ex(32'h66, 32'h66, 1'b0, 32'h0, 1'b1, 5'd4, 2'd0);
    @(negedge clk);
    set_ex(32'h77, 32'h40, 1'b0, 32'h0, 1'b1, 5'd8, 2'd1); flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_req", {31'h0, dmem_req}, 32'h0);
    chk("fl_stall", {31'h0, stall}, 32'h0);
    chk("fl_prev_rfwe", {31'h0, mem_rfWE}, 32'h1);
    nop();
    @(negedge clk);
    chk("fl_bubble", {31'h0, mem_rfWE}, 32'h0);
    chk("fl_inst", mem_inst, 32'h0);

    // Reset in the middle of a WAIT
    set_ex(32'h88, 32'h200, 1'b0, 32'h0, 1'b1, 5'd6, 2'd1);
    @(negedge clk); nop();
    @(negedge clk);
    chk("rw_pre_req", {31'h0, dmem_req}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rw_req", {31'h0, dmem_req}, 32'h0);
    chk("rw_stall", {31'h0, stall}, 32'h0);
    chk("rw_rfwe", {31'h0, mem_rfWE}, 32'h0);
    chk("rw_data", mem_rfData, 32'h0);
    chk("rw_err", {31'h0, mem_err}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rw_idle_req", {31'h0, dmem_req}, 32'h0);
    chk("rw_idle_rfwe", {31'h0, mem_rfWE}, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned load: no request, error pulse, bubble
    set_ex(32'h99, 32'h42, 1'b0, 32'h0, 1'b1, 5'd1, 2'd1);
    @(negedge clk);
    chk("al_req", {31'h0, dmem_req}, 32'h0);
    chk("al_stall", {31'h0, stall}, 32'h0);
    nop();
    @(negedge clk);
    chk("al_err", {31'h0, mem_err}, 32'h1);
    chk("al_rfwe", {31'h0, mem_rfWE}, 32'h0);
    @(negedge clk);
    chk("al_err_pulse", {31'h0, mem_err}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
